// File: rtl/cnt_pkg.sv
// Shared encodings and helpers for the modulo-N up/down counter.
// Imported by the counter RTL and its bench.
package cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Next-count and end-of-range logic for the modulo-N counter.
// Purely combinational; the register lives in the top.
module cnt_next_val
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] nxt,
  output logic             eor
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // +1/-1 are only taken away from the range ends, so they never overflow
  always_comb begin
    nxt = q;
    eor = 1'b0;
    if (up == CNT_UP) begin
      eor = (q == MAXV);
      if (!eor)
        nxt = q + ONE;
      else if (sat == CNT_WRAP)
        nxt = '0;
    end else begin
      eor = (q == '0);
      if (!eor)
        nxt = q - ONE;
      else if (sat == CNT_WRAP)
        nxt = MAXV;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter with load, clear,
// wrap/saturate mode and cascade carry.
module sync_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             load_err
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("sync_updown_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("sync_updown_counter: MODULUS out of range");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("sync_updown_counter: RESET_VAL out of range");
  end

  localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] nxt;
  logic             eor;
  logic             cnt;
  logic             d_bad;

  cnt_next_val #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_nxt (
    .q  (q),
    .up (up),
    .sat(sat),
    .nxt(nxt),
    .eor(eor)
  );

  // extra bit keeps MODULUS = 2**WIDTH representable
  assign d_bad = ({1'b0, d} >= MODW);
  assign cnt   = en & ci;
  assign tc    = cnt & eor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RV;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      priority case (1'b1)
        clr: q <= '0;
        load: begin
          q        <= d_bad ? MAXV : d;
          load_err <= d_bad;
        end
        cnt:     q <= nxt;
        default: q <= q;
      endcase
    end
  end

endmodule
